lfsr_checker: RTL
=================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16, consecutive correct predictions needed to lock.
REQ-002 SHALL have parameter LOSS_CNT, default 4, errors within one loss window that force loss of lock.
REQ-003 SHALL have parameter LOSS_WIN, default 32, loss window length in valid bits.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port bit_in  input  1  serial stream under test.
REQ-007 SHALL have port bit_valid  input  1  qualifies bit_in; when low, all state holds.
REQ-008 SHALL have port err_clr  input  1  synchronous clear of err_count.
REQ-009 SHALL have port locked  output  1  high while in LOCKED state.
REQ-010 SHALL have port err_pulse  output  1  one-cycle strobe per detected bit error.
REQ-011 SHALL have port err_count  output  16  number of errors detected while locked.

Function
REQ-012 SHALL check the 8-bit Fibonacci recursion b[n] = b[n-8] ^ b[n-6] ^ b[n-5] ^ b[n-4] (x^8+x^6+x^5+x^4+1).
REQ-013 SHALL keep an 8-bit history register sr (sr[0] newest) and a 4-bit fill counter; prediction p = sr[7]^sr[5]^sr[4]^sr[3].
REQ-014 SHALL implement FSM states FILL, SEARCH, LOCKED; only valid bits advance any state.
REQ-015 FILL: shift bit_in into sr; after the 8th valid bit, go to SEARCH with match counter 0.
REQ-016 SEARCH: compare bit_in to p; match increments the match counter, mismatch zeroes it; sr shifts in bit_in.
REQ-017 SEARCH: when sr is all-zero, count a mismatch regardless of bit_in (lockup exclusion).
REQ-018 SEARCH: on the valid bit that brings the match counter to LOCK_CNT, go to LOCKED; locked SHALL rise the following cycle.
REQ-019 LOCKED: sr SHALL shift in p (local generator), not bit_in, so a line error is counted once.
REQ-020 LOCKED: bit_in != p SHALL assert err_pulse for exactly the next cycle and increment err_count.
REQ-021 LOCKED: window counter counts valid bits 0..LOSS_WIN-1 and wraps, clearing the window error count on wrap.
REQ-022 LOCKED: on the error bringing the window count to LOSS_CNT, go to FILL, clear sr, fill, match and window counters; locked falls the next cycle.
REQ-023 err_count SHALL hold its value across lock loss and relock; only rst or err_clr clears it.
REQ-024 err_clr coincident with an error SHALL yield err_count = 1.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 rst high SHALL immediately force state FILL, sr = 0, all counters 0, locked = 0, err_pulse = 0, err_count = 0.
REQ-027 rst asserted mid-stream SHALL discard all lock history; relock requires 8 + LOCK_CNT valid bits after release.

Configuration
REQ-028 With macro LFSR_CHK_ERR_SAT_EN defined, err_count SHALL saturate at 16'hFFFF; err_pulse still fires per error.
REQ-029 Without LFSR_CHK_ERR_SAT_EN, err_count SHALL wrap from 16'hFFFF to 16'h0000.

Verification
REQ-030 Clean sequence seeded 8'h01, bit_valid always high -> locked rises 1 cycle after 24th valid bit, err_count = 0 after 1000 bits.
REQ-031 Locked, one bit inverted -> single err_pulse 1 cycle later, err_count = 1, locked stays high, no follow-on errors.
REQ-032 Locked, 4 inverted bits within 32 valid bits -> locked falls after 4th; clean stream resumes -> relock after 24 valid bits, err_count = 4.
REQ-033 Constant-zero input for 200 bits -> locked never asserts, err_count = 0.
REQ-034 bit_valid toggled every other cycle on clean stream -> lock after 24 valid bits (47 cycles); rst pulse while locked -> locked = 0 and err_count = 0 immediately.
REQ-035 err_count preloaded to 16'hFFFF via errors, one further error -> 16'hFFFF with LFSR_CHK_ERR_SAT_EN, 16'h0000 without.

Source files
------------

// File: rtl/lfsr_checker.sv
// Serial PRBS checker for x^8+x^6+x^5+x^4+1: fills, searches for lock, then self-generates and counts errors.
// Optional build macro LFSR_CHK_ERR_SAT_EN makes err_count saturate at 16'hFFFF instead of wrapping.
module lfsr_checker #(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int LOSS_WIN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        err_clr,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count
);

  localparam int MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int WIN_W   = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int WERR_W  = (LOSS_CNT > 1) ? $clog2(LOSS_CNT + 1) : 1;

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_SEARCH = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_sr;
  logic [7:0]          w_sr_nxt;
  logic [3:0]          r_fill;
  logic [3:0]          w_fill_nxt;
  logic [MATCH_W-1:0]  r_match;
  logic [MATCH_W-1:0]  w_match_nxt;
  logic [WIN_W-1:0]    r_win;
  logic [WIN_W-1:0]    w_win_nxt;
  logic [WERR_W-1:0]   r_werr;
  logic [WERR_W-1:0]   w_werr_nxt;
  logic [15:0]         r_err_count;
  logic [15:0]         w_err_count_nxt;
  logic                r_locked;
  logic                r_err_pulse;
  logic                w_pred;
  logic                w_sr_zero;
  logic                w_err;

  function automatic logic [15:0] f_err_inc(input logic [15:0] cnt);
`ifdef LFSR_CHK_ERR_SAT_EN
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
`else
    return cnt + 16'd1;
`endif
  endfunction

  assign w_pred    = r_sr[7] ^ r_sr[5] ^ r_sr[4] ^ r_sr[3];
  assign w_sr_zero = (r_sr == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_fill_nxt  = r_fill;
    w_match_nxt = r_match;
    w_win_nxt   = r_win;
    w_werr_nxt  = r_werr;
    w_err       = 1'b0;
    if (bit_valid) begin
      case (r_state)
        S_FILL: begin
          w_sr_nxt = {r_sr[6:0], bit_in};
          if (r_fill == 4'd7) begin
            w_state_nxt = S_SEARCH;
            w_fill_nxt  = 4'd0;
            w_match_nxt = '0;
          end else begin
            w_fill_nxt = r_fill + 4'd1;
          end
        end
        S_SEARCH: begin
          w_sr_nxt = {r_sr[6:0], bit_in};
          // An all-zero history is the LFSR lockup state and never counts as a match.
          if (!w_sr_zero && (bit_in == w_pred)) begin
            if (r_match == MATCH_W'(LOCK_CNT - 1)) begin
              w_state_nxt = S_LOCKED;
              w_match_nxt = '0;
              w_win_nxt   = '0;
              w_werr_nxt  = '0;
            end else begin
              w_match_nxt = r_match + MATCH_W'(1);
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        S_LOCKED: begin
          // Shift the local prediction so a single line error cannot corrupt later predictions.
          w_sr_nxt = {r_sr[6:0], w_pred};
          w_err    = (bit_in != w_pred);
          if (w_err && (r_werr == WERR_W'(LOSS_CNT - 1))) begin
            w_state_nxt = S_FILL;
            w_sr_nxt    = 8'd0;
            w_fill_nxt  = 4'd0;
            w_match_nxt = '0;
            w_win_nxt   = '0;
            w_werr_nxt  = '0;
          end else if (r_win == WIN_W'(LOSS_WIN - 1)) begin
            w_win_nxt  = '0;
            w_werr_nxt = '0;
          end else begin
            w_win_nxt  = r_win + WIN_W'(1);
            w_werr_nxt = r_werr + WERR_W'(w_err);
          end
        end
        default: begin
          w_state_nxt = S_FILL;
          w_sr_nxt    = 8'd0;
          w_fill_nxt  = 4'd0;
          w_match_nxt = '0;
          w_win_nxt   = '0;
          w_werr_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_err_count_nxt = r_err_count;
    if (err_clr) begin
      w_err_count_nxt = w_err ? 16'd1 : 16'd0;
    end else if (w_err) begin
      w_err_count_nxt = f_err_inc(r_err_count);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr        <= 8'd0;
      r_fill      <= 4'd0;
      r_match     <= '0;
      r_win       <= '0;
      r_werr      <= '0;
      r_err_count <= 16'd0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_sr        <= w_sr_nxt;
      r_fill      <= w_fill_nxt;
      r_match     <= w_match_nxt;
      r_win       <= w_win_nxt;
      r_werr      <= w_werr_nxt;
      r_err_count <= w_err_count_nxt;
      r_locked    <= (w_state_nxt == S_LOCKED);
      r_err_pulse <= w_err;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule
